// File: rtl/ir_pkg.sv
// Shared types and constants for the IR line-sensor sampling controller.
package ir_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned A2D_W  = 12;

  typedef logic [A2D_W-1:0]          ir_rd_t;
  typedef logic [$clog2(NUM_CH)-1:0] ir_ch_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONV,
    WAIT,
    DONE
  } ir_state_t;

endpackage

// File: rtl/ir_sample_ctrl_if.sv
// Conversion-request handshake between the sampling controller and the SPI A2D.
interface ir_sample_ctrl_if;
  import ir_pkg::*;

  logic   a2d_strt;
  ir_ch_t a2d_chnnl;
  logic   a2d_done;
  ir_rd_t a2d_res;

  modport master (
    output a2d_strt,
    output a2d_chnnl,
    input  a2d_done,
    input  a2d_res
  );

  modport slave (
    input  a2d_strt,
    input  a2d_chnnl,
    output a2d_done,
    output a2d_res
  );

endinterface

// File: rtl/period_timer.sv
// Free-running sweep pacing timer: counts 0..PERIOD-1 while enabled, held at 0 otherwise.
module period_timer #(
  parameter int unsigned PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned    TW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0]  LAST = TW'(PERIOD - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/ir_sample_ctrl.sv
// One sweep of the eight IR line sensors: emitter settle, eight ordered A2D
// conversions into a register file, then a one-cycle IR_vld pulse.
module ir_sample_ctrl
  import ir_pkg::*;
#(
  parameter int unsigned PERIOD = 1_000_000,
  parameter int unsigned SETTLE = 2048
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  ir_sample_ctrl_if.master         a2d,
  output logic                     IR_en,
  input  ir_ch_t                   rd_sel,
  output ir_rd_t                   rd_data,
  output logic                     IR_vld,
  output logic                     busy,
  output logic                     ovr
);

  localparam int unsigned   SW          = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam ir_ch_t        LAST_CH     = ir_ch_t'(NUM_CH - 1);

  ir_state_t     state_q;
  logic [SW-1:0] settle_q;
  ir_ch_t        ch_q;
  ir_rd_t        rd_q [NUM_CH];
  logic          ovr_q;
  logic          tick;

  period_timer #(
    .PERIOD(PERIOD)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (go),
    .tick (tick)
  );

  // The parameter SETTLE shadows the imported state literal, hence the qualified name.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      ch_q     <= '0;
      ovr_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      if (!go) begin
        ovr_q <= 1'b0;
      end else if (tick && (state_q != IDLE)) begin
        ovr_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q  <= ir_pkg::SETTLE;
            settle_q <= '0;
            ch_q     <= '0;
          end
        end
        ir_pkg::SETTLE: begin
          settle_q <= settle_q + 1'b1;
          if (settle_q == SETTLE_LAST) begin
            state_q <= CONV;
          end
        end
        CONV: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (a2d.a2d_done) begin
            rd_q[ch_q] <= a2d.a2d_res;
            if (ch_q == LAST_CH) begin
              state_q <= DONE;
            end else begin
              ch_q    <= ch_q + 1'b1;
              state_q <= CONV;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a2d.a2d_strt  = (state_q == CONV);
  assign a2d.a2d_chnnl = ch_q;
  assign IR_en         = (state_q == ir_pkg::SETTLE) || (state_q == CONV) || (state_q == WAIT);
  assign IR_vld        = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign ovr           = ovr_q;
  assign rd_data       = rd_q[rd_sel];

endmodule

// File: tb/tb_ir_sample_ctrl.sv
// Bench for ir_sample_ctrl: cycle-by-cycle comparison against a timeline model of
// the sweep, a reactive A2D responder, a read-port vector table and corner sequences.
module tb_ir_sample_ctrl;
  import ir_pkg::*;

  localparam int unsigned PERIOD   = 100;
  localparam int unsigned SETTLE_C = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic [2:0]  rd_sel;
  logic [11:0] rd_data;
  logic        IR_en, IR_vld, busy, ovr;

  ir_sample_ctrl_if a2d_if ();

  ir_sample_ctrl #(
    .PERIOD(PERIOD),
    .SETTLE(SETTLE_C)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .a2d    (a2d_if),
    .IR_en  (IR_en),
    .rd_sel (rd_sel),
    .rd_data(rd_data),
    .IR_vld (IR_vld),
    .busy   (busy),
    .ovr    (ovr)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [16];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Timeline model: a sweep is described by its channel, the cycle its next
  // request is due and the cycle of its completion pulse.
  int m_gorun;
  bit m_act;
  int m_ch;
  int m_strt_cyc;
  int m_vld_cyc;
  bit m_ovr;
  int m_mem [8];

  // Stimulus controls and the reactive A2D responder.
  bit          go_v, rst_v, arm_rst4, inj_spur, rnd_res, lat_rand;
  int          lat;
  int          done_at;
  logic [11:0] pend_res;
  logic [11:0] resp_q [$];

  int n_strt, n_vld, n_en, first_en, first_strt;
  int strt_ch [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_gorun    = 0;
    m_act      = 1'b0;
    m_ch       = 0;
    m_strt_cyc = -1;
    m_vld_cyc  = -1;
    m_ovr      = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 0;
    done_at    = -1;
  endtask

  task automatic model_update(input bit dn, input logic [11:0] rs);
    bit tick;
    bit waiting;
    tick    = go && ((m_gorun % int'(PERIOD)) == int'(PERIOD) - 1);
    waiting = m_act && (m_vld_cyc < 0) && (cyc > m_strt_cyc);
    if (waiting && dn) begin
      m_mem[m_ch] = int'(rs);
      if (m_ch == 7) m_vld_cyc = cyc + 1;
      else begin
        m_ch++;
        m_strt_cyc = cyc + 1;
      end
    end
    if (!go) m_ovr = 1'b0;
    else if (tick && m_act) m_ovr = 1'b1;
    if (m_act) begin
      if (cyc == m_vld_cyc) m_act = 1'b0;
    end else if (tick) begin
      m_act      = 1'b1;
      m_ch       = 0;
      m_strt_cyc = cyc + 1 + int'(SETTLE_C);
      m_vld_cyc  = -1;
    end
    m_gorun = go ? m_gorun + 1 : 0;
  endtask

  task automatic step();
    logic        dn;
    logic [11:0] rs;
    @(negedge clk);
    if (arm_rst4 && m_act && (cyc == m_strt_cyc) && (m_ch == 4)) begin
      rst_v    = 1'b0;
      arm_rst4 = 1'b0;
    end
    dn = (cyc == done_at) || inj_spur;
    if (inj_spur) rs = 12'hFFF;
    else if (cyc == done_at) rs = pend_res;
    else rs = 12'($urandom);
    inj_spur = 1'b0;
    rst_n = rst_v;
    go = go_v;
    a2d_if.a2d_done = dn;
    a2d_if.a2d_res = rs;
    rd_sel = 3'($urandom);
    #1;
    if (!rst_n) model_reset();
    chk("busy", busy, m_act);
    chk("IR_en", IR_en, m_act && (cyc != m_vld_cyc));
    chk("a2d_strt", a2d_if.a2d_strt, m_act && (cyc == m_strt_cyc));
    chk("IR_vld", IR_vld, m_act && (cyc == m_vld_cyc));
    chk("a2d_chnnl", a2d_if.a2d_chnnl, m_ch);
    chk("ovr", ovr, m_ovr);
    chk("rd_data", rd_data, m_mem[rd_sel]);
    if (IR_en) begin
      n_en++;
      if (first_en < 0) first_en = cyc;
    end
    if (IR_vld) n_vld++;
    if (a2d_if.a2d_strt) begin
      n_strt++;
      if (first_strt < 0) first_strt = cyc;
      strt_ch.push_back(int'(a2d_if.a2d_chnnl));
      done_at  = cyc + (lat_rand ? int'($urandom_range(2, 6)) : lat);
      pend_res = rnd_res ? 12'($urandom) : (12'h100 + 12'(a2d_if.a2d_chnnl));
      resp_q.push_back(pend_res);
    end
    if (rst_n) model_update(dn, rs);
    cyc++;
  endtask

  // Must be called straight after step(): it uses the remaining half clock period.
  task automatic apply_table(input int lo, input int hi, input string nm);
    for (int i = lo; i <= hi; i++) begin
      rd_sel = tbl[i].sel;
      #1;
      chk(nm, rd_data, tbl[i].exp);
    end
  endtask

  task automatic wait_vld(input int maxc, input string nm);
    int v0;
    v0 = n_vld;
    for (int i = 0; i < maxc && n_vld == v0; i++) step();
    chk(nm, n_vld - v0, 1);
  endtask

  task automatic drain(input int maxc, input string nm);
    for (int i = 0; i < maxc && busy; i++) step();
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int t0, s0, v0, e0, tr;
    bit saw_ovr;
    int sn [8];

    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{3'(i), 12'h000};
      tbl[8 + i] = '{3'(7 - i), 12'h100 + 12'(7 - i)};
    end

    rst_n = 1'b0; go = 1'b0; rd_sel = '0;
    a2d_if.a2d_done = 1'b0; a2d_if.a2d_res = '0;
    rst_v = 1'b0; go_v = 1'b0; arm_rst4 = 1'b0; inj_spur = 1'b0;
    rnd_res = 1'b0; lat_rand = 1'b0; lat = 3;
    n_strt = 0; n_vld = 0; n_en = 0; first_en = -1; first_strt = -1;
    model_reset();

    repeat (3) step();
    apply_table(0, 7, "reset_reading");
    rst_v = 1'b1;
    step();

    // Basic sweep: fixed 3-cycle A2D latency returning 0x100+ch.
    go_v = 1'b1;
    t0 = cyc;
    first_en = -1; first_strt = -1; s0 = n_strt; strt_ch.delete();
    wait_vld(300, "t1_vld_once");
    chk("t1_en_rise", first_en - t0, PERIOD);
    chk("t1_first_strt", first_strt - t0, PERIOD + SETTLE_C);
    chk("t1_strt_count", n_strt - s0, 8);
    for (int i = 0; i < strt_ch.size(); i++) chk("t1_ch_order", strt_ch[i], i);
    apply_table(8, 15, "t1_reading");
    go_v = 1'b0;
    step();
    rd_sel = 3'd5;
    #1;
    chk("t1_sel5", rd_data, 12'h105);
    drain(20, "t1_idle");

    // Long A2D latency: ticks are dropped mid-sweep.
    lat = 200; rnd_res = 1'b1; go_v = 1'b1; saw_ovr = 1'b0;
    v0 = n_vld;
    for (int i = 0; i < 2500 && n_vld == v0; i++) begin
      step();
      if (ovr) saw_ovr = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      chk("t2_reading", rd_data, (resp_q.size() >= 8) ? resp_q[resp_q.size() - 8 + i] : 12'hxxx);
    end
    chk("t2_vld_once", n_vld - v0, 1);
    chk("t2_ovr_set", saw_ovr, 1'b1);
    go_v = 1'b0;
    step();
    step();
    chk("t2_ovr_cleared", ovr, 1'b0);
    drain(3000, "t2_idle");

    // go dropped while waiting on channel 3.
    lat_rand = 1'b1; go_v = 1'b1;
    for (int i = 0; i < 400 && !(busy && IR_en && !a2d_if.a2d_strt && a2d_if.a2d_chnnl == 3'd3); i++)
      step();
    chk("t3_reach_ch3", a2d_if.a2d_chnnl, 3);
    go_v = 1'b0;
    s0 = n_strt; v0 = n_vld;
    strt_ch.delete();
    for (int i = 0; i < 200 && n_vld == v0; i++) step();
    chk("t3_strt_count", n_strt - s0, 4);
    chk("t3_vld_once", n_vld - v0, 1);
    for (int i = 0; i < strt_ch.size(); i++) chk("t3_ch_order", strt_ch[i], 4 + i);
    drain(10, "t3_idle");
    e0 = n_en;
    repeat (3 * PERIOD) step();
    chk("t3_no_en", n_en - e0, 0);

    // Spurious a2d_done with 0xFFF in IDLE and in SETTLE.
    lat_rand = 1'b0; lat = 3; rnd_res = 1'b0;
    foreach (sn[i]) sn[i] = m_mem[i];
    inj_spur = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      chk("t4_idle_keep", rd_data, sn[i]);
    end
    go_v = 1'b1;
    for (int i = 0; i < 300 && !busy; i++) step();
    step();
    inj_spur = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      chk("t4_settle_keep", rd_data, sn[i]);
    end
    wait_vld(100, "t4_vld_once");
    apply_table(8, 15, "t4_reading");
    go_v = 1'b0;
    drain(10, "t4_idle");

    // Reset pulse during the CONV cycle of channel 4.
    go_v = 1'b1; arm_rst4 = 1'b1;
    for (int i = 0; i < 400 && rst_n; i++) step();
    chk("t5_rst_hit", rst_n, 1'b0);
    chk("t5_outputs_zero", {IR_en, a2d_if.a2d_strt, IR_vld, busy, ovr, a2d_if.a2d_chnnl}, 0);
    apply_table(0, 7, "t5_reading_zero");
    step();
    rst_v = 1'b1;
    tr = cyc;
    first_en = -1;
    for (int i = 0; i < 300 && first_en < 0; i++) step();
    chk("t5_restart", first_en - tr, PERIOD);
    go_v = 1'b0;
    drain(200, "t5_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
